// File: rtl/cordic_fifo_ctrl.sv
// Pointer, occupancy and read-latency controller for the CORDIC FIFO dual-port LSRAM.
// Write and read data go straight to and from the RAM; only addresses, enables and flags are produced here.
module cordic_fifo_ctrl #(
    parameter int DEPTH         = 128,
    parameter int AWIDTH        = 7,
    parameter int AFULL_THRESH  = 120,
    parameter int AEMPTY_THRESH = 8,
    parameter int RD_LATENCY    = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WE,
    input  logic              RE,
    output logic [AWIDTH-1:0] RAM_WADDR,
    output logic              RAM_WEN,
    output logic [AWIDTH-1:0] RAM_RADDR,
    output logic              RAM_REN,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic [AWIDTH:0]   WRCNT,
    output logic              DVLD,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam logic [AWIDTH:0]   DEPTH_CNT  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   AFULL_CNT  = (AWIDTH+1)'(AFULL_THRESH);
    localparam logic [AWIDTH:0]   AEMPTY_CNT = (AWIDTH+1)'(AEMPTY_THRESH);
    localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(DEPTH - 1);

    logic [AWIDTH-1:0]     wr_ptr;
    logic [AWIDTH-1:0]     rd_ptr;
    logic [AWIDTH:0]       count;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_acc;
    logic                  rd_acc;

    // Accept decisions use the registered count, so a write never falls through to a same-cycle read.
    always_comb begin
        wr_acc = WE & ~FULL & ~RESET;
        rd_acc = RE & ~EMPTY & ~RESET;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            vld_pipe  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AWIDTH'(1);
            if (rd_acc)
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AWIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AWIDTH+1)'(1);
                2'b01:   count <= count - (AWIDTH+1)'(1);
                default: count <= count;
            endcase
            // Read-latency shift register: bit k is a read accepted k+1 cycles ago.
            vld_pipe[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (WE && FULL)
                overflow <= 1'b1;
            if (RE && EMPTY)
                underflow <= 1'b1;
        end
    end

    always_comb begin
        RAM_WADDR = wr_ptr;
        RAM_RADDR = rd_ptr;
        RAM_WEN   = wr_acc;
        RAM_REN   = rd_acc;
        WRCNT     = count;
        FULL      = (count == DEPTH_CNT);
        EMPTY     = (count == '0);
        AFULL     = (count >= AFULL_CNT);
        AEMPTY    = (count <= AEMPTY_CNT);
        DVLD      = vld_pipe[RD_LATENCY-1];
        OVERFLOW  = overflow;
        UNDERFLOW = underflow;
    end

endmodule

// File: tb/tb_cordic_fifo_ctrl.sv
// Randomized and directed bench for cordic_fifo_ctrl against a queue-based FIFO reference model.
module tb_cordic_fifo_ctrl;

    localparam int DEPTH  = 128;
    localparam int AW     = 7;
    localparam int AFT    = 120;
    localparam int AET    = 8;
    localparam int LAT    = 2;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          WE = 1'b0;
    logic          RE = 1'b0;
    logic [AW-1:0] RAM_WADDR;
    logic          RAM_WEN;
    logic [AW-1:0] RAM_RADDR;
    logic          RAM_REN;
    logic          FULL;
    logic          EMPTY;
    logic          AFULL;
    logic          AEMPTY;
    logic [AW:0]   WRCNT;
    logic          DVLD;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    cordic_fifo_ctrl #(
        .DEPTH(DEPTH), .AWIDTH(AW), .AFULL_THRESH(AFT),
        .AEMPTY_THRESH(AET), .RD_LATENCY(LAT)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .WE(WE), .RE(RE),
        .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN),
        .RAM_RADDR(RAM_RADDR), .RAM_REN(RAM_REN),
        .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY),
        .WRCNT(WRCNT), .DVLD(DVLD), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    int vectors = 0;
    int errors  = 0;

    // Reference model: occupancy, accepted-write/read totals, stored addresses, DVLD due times.
    int occ = 0;
    int wr_total = 0;
    int rd_total = 0;
    int cyc = 0;
    bit ovf = 0;
    bit unf = 0;
    int wq[$];
    int dv_due[$];
    int dvld_seen;

    // One clock of stimulus with the reference model scoring every output.
    task automatic cycle(input logic we, input logic re, input logic rst);
        logic wacc, racc, full_b, empty_b, exp_dv;
        int   exp_raddr;
        @(negedge CLOCK);
        WE = we; RE = re; RESET = rst;
        full_b  = (occ == DEPTH);
        empty_b = (occ == 0);
        wacc = we && !rst && !full_b;
        racc = re && !rst && !empty_b;
        exp_raddr = racc ? wq[0] : (rd_total % DEPTH);
        #1;
        vectors++;
        if (RAM_WEN !== wacc) begin
            errors++; $display("FAIL ram_wen cyc %0d: got %b want %b", cyc, RAM_WEN, wacc);
        end
        vectors++;
        if (RAM_REN !== racc) begin
            errors++; $display("FAIL ram_ren cyc %0d: got %b want %b", cyc, RAM_REN, racc);
        end
        if (!rst) begin
            vectors++;
            if (RAM_WADDR !== AW'(wr_total % DEPTH)) begin
                errors++; $display("FAIL ram_waddr cyc %0d: got %0d want %0d", cyc, RAM_WADDR, wr_total % DEPTH);
            end
            vectors++;
            if (RAM_RADDR !== AW'(exp_raddr)) begin
                errors++; $display("FAIL ram_raddr cyc %0d: got %0d want %0d", cyc, RAM_RADDR, exp_raddr);
            end
        end
        @(posedge CLOCK);
        #1;
        if (rst) begin
            occ = 0; wr_total = 0; rd_total = 0; ovf = 0; unf = 0;
            wq.delete(); dv_due.delete();
        end else begin
            if (racc) begin
                void'(wq.pop_front()); rd_total++; occ--; dv_due.push_back(cyc + LAT);
            end
            if (wacc) begin
                wq.push_back(wr_total % DEPTH); wr_total++; occ++;
            end
            if (we && full_b) ovf = 1;
            if (re && empty_b) unf = 1;
        end
        cyc++;
        exp_dv = (dv_due.size() > 0 && dv_due[0] == cyc);
        if (exp_dv) void'(dv_due.pop_front());
        vectors++;
        if (WRCNT !== (AW+1)'(occ)) begin
            errors++; $display("FAIL wrcnt cyc %0d: got %0d want %0d", cyc, WRCNT, occ);
        end
        vectors++;
        if ({FULL, EMPTY, AFULL, AEMPTY} !== {occ == DEPTH, occ == 0, occ >= AFT, occ <= AET}) begin
            errors++; $display("FAIL flags(full,empty,afull,aempty) cyc %0d: got %b%b%b%b want %b%b%b%b", cyc,
                FULL, EMPTY, AFULL, AEMPTY, occ == DEPTH, occ == 0, occ >= AFT, occ <= AET);
        end
        vectors++;
        if ({OVERFLOW, UNDERFLOW} !== {ovf, unf}) begin
            errors++; $display("FAIL sticky(ovf,unf) cyc %0d: got %b%b want %b%b", cyc, OVERFLOW, UNDERFLOW, ovf, unf);
        end
        vectors++;
        if (DVLD !== exp_dv) begin
            errors++; $display("FAIL dvld cyc %0d: got %b want %b", cyc, DVLD, exp_dv);
        end
        if (DVLD === 1'b1) dvld_seen++;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        vectors++;
        if ({EMPTY, AEMPTY, FULL, AFULL, DVLD, OVERFLOW, UNDERFLOW} !== 7'b1100000 || WRCNT !== '0) begin
            errors++; $display("FAIL reset_state: got flags %b cnt %0d want 1100000 cnt 0",
                {EMPTY, AEMPTY, FULL, AFULL, DVLD, OVERFLOW, UNDERFLOW}, WRCNT);
        end
        vectors++;
        if (RAM_WADDR !== '0 || RAM_RADDR !== '0) begin
            errors++; $display("FAIL reset_addr: got w %0d r %0d want 0 0", RAM_WADDR, RAM_RADDR);
        end
    endtask

    task automatic test_write3();
        cycle(1, 0, 0);
        vectors++;
        if (EMPTY !== 1'b0) begin
            errors++; $display("FAIL write3_empty_fall: got %b want 0", EMPTY);
        end
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        vectors++;
        if (WRCNT !== 8'd3) begin
            errors++; $display("FAIL write3_cnt: got %0d want 3", WRCNT);
        end
    endtask

    task automatic test_read3();
        dvld_seen = 0;
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        vectors++;
        if (dvld_seen != 3 || EMPTY !== 1'b1 || UNDERFLOW !== 1'b0) begin
            errors++; $display("FAIL read3: got dvld %0d empty %b unf %b want 3 1 0", dvld_seen, EMPTY, UNDERFLOW);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1, 0, 0);
            if (i == AFT - 1 || i == AFT) begin
                vectors++;
                if (AFULL !== (i >= AFT)) begin
                    errors++; $display("FAIL fill_afull at %0d: got %b want %b", i, AFULL, i >= AFT);
                end
            end
        end
        vectors++;
        if (FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL fill_full: got full %b ovf %b want 1 0", FULL, OVERFLOW);
        end
        cycle(1, 0, 0);
        vectors++;
        if (OVERFLOW !== 1'b1 || WRCNT !== 8'd128) begin
            errors++; $display("FAIL fill_overflow: got ovf %b cnt %0d want 1 128", OVERFLOW, WRCNT);
        end
        cycle(1, 1, 0);
        vectors++;
        if (WRCNT !== 8'd127) begin
            errors++; $display("FAIL full_wr_rd: got cnt %0d want 127", WRCNT);
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        dvld_seen = 0;
        for (int i = 0; i < 200; i++) cycle(1, 1, 0);
        vectors++;
        if (WRCNT !== 8'd5 || dvld_seen != 199) begin
            errors++; $display("FAIL back_to_back: got cnt %0d dvld %0d want 5 199", WRCNT, dvld_seen);
        end
    endtask

    task automatic test_empty_rw();
        cycle(0, 0, 1);
        dvld_seen = 0;
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        vectors++;
        if (UNDERFLOW !== 1'b1 || WRCNT !== 8'd1 || dvld_seen != 0) begin
            errors++; $display("FAIL empty_rw: got unf %b cnt %0d dvld %0d want 1 1 0", UNDERFLOW, WRCNT, dvld_seen);
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        cycle(0, 1, 1);
        cycle(1, 0, 0);
        dvld_seen = 0;
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        vectors++;
        if (dvld_seen != 0 || {EMPTY, AEMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW} !== 6'b110000) begin
            errors++; $display("FAIL reset_flush: got dvld %0d flags %b want 0 110000",
                dvld_seen, {EMPTY, AEMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW});
        end
    endtask

    task automatic test_random();
        int wbias;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) wbias = $urandom_range(1, 9);
            cycle($urandom_range(0, 9) < wbias, $urandom_range(0, 9) >= wbias,
                  $urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read3();
        test_fill();
        test_back_to_back();
        test_empty_rw();
        test_reset_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cordic_fifo_ctrl.md
Name: cordic_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the CORDIC FIFO's dual-port LSRAM wrapper.
- Accepts user write/read requests and generates the RAM write/read addresses and enables.
- Tracks occupancy and produces full/empty/almost flags and sticky error flags.
- Tracks the RAM's pipelined read latency and produces a read-data-valid strobe aligned with the RAM's RDATA.
- Sits between the CORDIC output stage (writer) and the downstream calibrator consumer (reader). Write data and read data pass directly to and from the RAM and do not go through this block.

Parameters:
- DEPTH, 128, number of RAM words; any value from 2 to 2^AWIDTH.
- AWIDTH, 7, RAM address width.
- AFULL_THRESH, 120, AFULL asserts when WRCNT >= this value.
- AEMPTY_THRESH, 8, AEMPTY asserts when WRCNT <= this value.
- RD_LATENCY, 2, cycles from an accepted read (RAM_REN high) to valid RAM RDATA; 2 matches the pipelined-output RAM; legal range 1 to 4.

Ports:
- CLOCK, in, 1, single system clock; all logic is rising-edge.
- RESET, in, 1, synchronous, active-high reset.
- WE, in, 1, write request from the producer.
- RE, in, 1, read request from the consumer.
- RAM_WADDR, out, AWIDTH, RAM write address.
- RAM_WEN, out, 1, RAM write enable.
- RAM_RADDR, out, AWIDTH, RAM read address.
- RAM_REN, out, 1, RAM read enable.
- FULL, out, 1, WRCNT == DEPTH.
- EMPTY, out, 1, WRCNT == 0.
- AFULL, out, 1, almost full.
- AEMPTY, out, 1, almost empty.
- WRCNT, out, AWIDTH+1, current occupancy.
- DVLD, out, 1, RAM RDATA is valid this cycle.
- OVERFLOW, out, 1, sticky: a write was rejected.
- UNDERFLOW, out, 1, sticky: a read was rejected.

Behaviour:
- Reset: while RESET is high at a rising edge, the following go to 0 on that edge:
  - write and read pointers, WRCNT, DVLD pipeline, OVERFLOW, UNDERFLOW.
  - Resulting outputs: EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, DVLD=0, RAM_WADDR=0, RAM_RADDR=0.
  - RAM_WEN=0 and RAM_REN=0 while RESET is high.
  - Reset overrides any request in the same cycle.
  - Reset in the middle of a read flushes in-flight DVLD; no DVLD pulse appears after reset for a read accepted before it.
  - RAM contents are not cleared.
- Accept rules (combinational, same cycle):
  - wr_acc = WE & ~FULL.
  - rd_acc = RE & ~EMPTY.
  - RAM_WEN = wr_acc; RAM_REN = rd_acc.
  - RAM_WADDR = write pointer; RAM_RADDR = read pointer (registered pointers driven directly).
  - Writes do not fall through: a write and a read in the same cycle on an empty FIFO accept only the write.
  - On a full FIFO, a write is rejected even if a read is accepted in the same cycle.
- Pointers:
  - Each pointer increments by 1 on its accept.
  - Each wraps from DEPTH-1 to 0 by explicit compare, so non-power-of-two DEPTH works.
- Occupancy:
  - WRCNT next = WRCNT + wr_acc - rd_acc.
  - Both accepted: unchanged. Width AWIDTH+1, never exceeds DEPTH and never goes below 0.
  - FULL, EMPTY, AFULL and AEMPTY are decoded from the registered WRCNT, so they update the cycle after the accept.
- Latency:
  - DVLD is rd_acc delayed by exactly RD_LATENCY cycles through a shift register.
  - Back-to-back reads give back-to-back DVLD pulses.
- Errors:
  - OVERFLOW sets on WE & FULL; UNDERFLOW sets on RE & EMPTY.
  - Both stay set until RESET.
  - Rejected requests change no other state.
- There is no state machine beyond the pointer, count and latency registers; the RAM sees at most one write and one read per cycle.

Test Plan:
1. Reset, then write 3 words (WE for 3 cycles) -> RAM_WADDR 0, 1, 2 with RAM_WEN=1; WRCNT=3; EMPTY falls the cycle after the first write.
2. Read 3 words after test 1 -> RAM_RADDR 0, 1, 2; DVLD high on cycles t+2, t+3, t+4; EMPTY=1 afterwards; UNDERFLOW stays 0.
3. Fill to 128, then WE once more -> FULL=1, AFULL set once WRCNT reaches 120, RAM_WEN=0 on the extra write, OVERFLOW=1, WRCNT=128.
4. Simultaneous WE and RE with WRCNT=5 over 200 cycles -> WRCNT stays 5; both pointers wrap 127->0 and the read sequence matches the write sequence.
5. RE on an empty FIFO together with WE -> only the write is accepted, UNDERFLOW=1, WRCNT=1, no DVLD.
6. Accept a read, then assert RESET on the next cycle -> DVLD never pulses; all flags return to reset values; OVERFLOW and UNDERFLOW are cleared.
